fir_stream_driver: RTL and testbench
====================================

// Module: fir_stream_driver
// PURPOSE
// - Initiator that feeds the FIR filter block: holds a host-written coefficient shadow, replays it into the FIR config
//   port on request, then streams 8-bit samples into the FIR under its done handshake and buffers filtered results.
// - Sits between the host/ADC sample interface and the FIR; the FIR side of every port pairs 1:1 with FIR pins.
// PARAMETERS
// - DW        8    sample/coefficient width (Q1.7); fixed at 8 for the current FIR
// - MAX_TAPS  16   coefficient shadow depth; tap code 0..MAX_TAPS-1 means 1..MAX_TAPS taps
// - RES_DEPTH 4    result FIFO depth (power of 2, >=2)
// - TMO_CYC   64   cycles to wait for fir_done before flagging timeout
// PORTS
// - clk               in   1      single clock, rising edge
// - rst_n             in   1      asynchronous active-low reset
// - cfg_wr            in   1      write shadow entry cfg_addr with cfg_wdata
// - cfg_addr          in   5      0 = tap code (bits 3:0), 1..16 = h_0..h_15
// - cfg_wdata         in   8      shadow write data
// - cfg_start         in   1      pulse: replay shadow into FIR
// - cfg_busy          out  1      high from cfg_start accept until replay finished
// - smp_valid/smp_ready in/out 1  sample handshake (transfer when both high)
// - smp_data          in   8      sample, two's complement Q1.7
// - res_valid/res_ready out/in 1  result handshake from FIFO head
// - res_data          out  8      filtered sample
// - res_ovf           out  2      00 none, 01 positive sat, 10 negative sat
// - tmo_err           out  1      sticky: fir_done not seen within TMO_CYC; cleared by cfg_start
// - fir_data_in       out  8      sample or config byte to FIR
// - fir_enable        out  1      one-cycle launch of a sample
// - fir_configuration out  1      one-cycle config request
// - fir_config_data_enable out 1  qualifies config bytes on fir_data_in
// - fir_data_out / fir_overflow_flag / fir_done  in 8/2/1  FIR result, flag, ready-for-new-data
// BEHAVIOUR
// - Reset: all outputs 0, shadow cleared (tap code 0), FIFO empty, FSM IDLE, tmo_err 0.
// - FSM: IDLE -> CFG_REQ -> CFG_DATA -> IDLE; IDLE -> LAUNCH -> WAIT_LO -> WAIT_HI -> IDLE.
// - cfg_start accepted only in IDLE (ignored elsewhere, except latched as pending while streaming; taken on return to IDLE).
// - CFG_REQ: fir_configuration=1 one cycle. CFG_DATA: fir_config_data_enable=1 for tap code byte then h_0..h_N-1,
//   one byte per cycle, N=tap code+1; total N+1 data cycles; cfg_busy drops the cycle after last byte.
// - cfg_wr during cfg_busy is ignored (shadow stable during replay). cfg_addr>16 ignored.
// - Config has priority over samples when both pending in IDLE; smp_ready=0 while cfg_busy.
// - smp_ready=1 only in IDLE, fir_done=1, no config pending, and FIFO has >=1 free slot counting the in-flight result.
// - LAUNCH: on sample transfer, fir_data_in<=smp_data, fir_enable=1 for exactly one cycle.
// - WAIT_LO waits fir_done=0, WAIT_HI waits fir_done=1; on fir_done rising, fir_data_out/fir_overflow_flag pushed into FIFO
//   same cycle. Throughput one sample per FIR cycle; no overlapping launches.
// - Timeout counter runs in WAIT_LO/WAIT_HI; at TMO_CYC cycles: tmo_err=1, FSM to IDLE, no FIFO push.
// - FIFO: push+pop same cycle when full or empty both legal; count unchanged; res_* registered from head, stable while res_ready=0.
// - fir_data_in holds last driven value when idle; fir_enable/config strobes never coincide.
// CONFIGURATION
// - FIR_DRV_OVF_CNT_EN defined: adds outputs ovf_pos_cnt[15:0], ovf_neg_cnt[15:0], saturating counters incremented on
//   FIFO push with flag 01/10, cleared by reset and cfg_start. Undefined: ports and counters absent, no other change.
// STRUCTURE
// - Shared package fir_pkg: DW, MAX_TAPS, overflow codes (OVF_NONE/POS/NEG), FSM state enum, cfg_addr map constants.
// - One sub-module: fir_res_fifo (RES_DEPTH x 10-bit sync FIFO, full/empty/count); rest is FSM + shadow + timer.
// TESTING
// - Write tap code 3, h=0x40,0x20,0x10,0x08; cfg_start -> 1 cycle fir_configuration, then bytes 03,40,20,10,08 with strobe.
// - Stream 0x7F,0x00,0x80 with fir_done model of 4-cycle latency -> three launches, results pushed in order, res_ovf copied.
// - Hold res_ready=0 for RES_DEPTH+2 samples -> smp_ready drops after RES_DEPTH launches; no result lost or overwritten.
// - Hold fir_done low 64 cycles after launch -> tmo_err=1, FSM IDLE, FIFO count unchanged; cfg_start clears it.
// - cfg_start during WAIT_HI -> replay begins after result push; cfg_wr during replay leaves shadow unchanged.
// - Assert rst_n=0 mid-CFG_DATA -> all outputs 0 asynchronously, shadow cleared, cfg_busy=0 after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR driver definitions: widths, overflow codes, FSM states and the host config address map.
// Imported by fir_res_fifo and fir_stream_driver.
package fir_pkg;

   localparam int DW       = 8;
   localparam int MAX_TAPS = 16;

   localparam logic [1:0] OVF_NONE = 2'b00;
   localparam logic [1:0] OVF_POS  = 2'b01;
   localparam logic [1:0] OVF_NEG  = 2'b10;

   localparam logic [4:0] ADDR_TAPS    = 5'd0;
   localparam logic [4:0] ADDR_H_FIRST = 5'd1;
   localparam logic [4:0] ADDR_H_LAST  = 5'(MAX_TAPS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG_REQ,
      ST_CFG_DATA,
      ST_LAUNCH,
      ST_WAIT_LO,
      ST_WAIT_HI
   } state_t;

   typedef struct packed {
      logic [1:0]    ovf;
      logic [DW-1:0] data;
   } res_t;

endpackage

// File: rtl/fir_res_fifo.sv
// Synchronous result FIFO; head is read straight from the storage registers, push visible the next cycle.
// Push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module fir_res_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one being popped, so a simultaneous push is safe.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fir_stream_driver.sv
// FIR initiator: replays host coefficient shadow into the FIR, then streams samples under fir_done and buffers results.
// One sample per FIR cycle; smp_ready held low while config runs/pends or result FIFO lacks a slot. Option: FIR_DRV_OVF_CNT_EN.
module fir_stream_driver
   import fir_pkg::*;
#(
   parameter int RES_DEPTH = 4,
   parameter int TMO_CYC   = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_wr,
   input  logic [4:0]    cfg_addr,
   input  logic [DW-1:0] cfg_wdata,
   input  logic          cfg_start,
   output logic          cfg_busy,
   input  logic          smp_valid,
   output logic          smp_ready,
   input  logic [DW-1:0] smp_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [1:0]    res_ovf,
   output logic          tmo_err,
   output logic [DW-1:0] fir_data_in,
   output logic          fir_enable,
   output logic          fir_configuration,
   output logic          fir_config_data_enable,
   input  logic [DW-1:0] fir_data_out,
   input  logic [1:0]    fir_overflow_flag,
   input  logic          fir_done
`ifdef FIR_DRV_OVF_CNT_EN
   ,
   output logic [15:0]   ovf_pos_cnt,
   output logic [15:0]   ovf_neg_cnt
`endif
);

   localparam int CW = $clog2(RES_DEPTH) + 1;
   localparam int TW = $clog2(TMO_CYC);

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    tap_code;
   logic [DW-1:0] coef [MAX_TAPS];
   logic [4:0]    byte_idx;
   logic [DW-1:0] data_q;
   logic          cfg_pend;
   logic          run;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_q;

   logic          cfg_take;
   logic          smp_xfer;
   logic          res_push;
   logic          tmo_hit;
   logic          tmo_expired;
   logic          last_byte;
   logic          in_flight;
   logic          fifo_room;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_cnt;
   res_t          fifo_head;
   res_t          push_word;

   assign in_flight   = (state == ST_LAUNCH) || (state == ST_WAIT_LO) || (state == ST_WAIT_HI);
   assign fifo_room   = !fifo_full && ((fifo_cnt + CW'(in_flight)) < CW'(RES_DEPTH));
   assign last_byte   = (byte_idx == (5'(tap_code) + 5'd1));
   assign tmo_expired = (tmo_cnt == TW'(TMO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt              = state;
      cfg_take               = 1'b0;
      smp_xfer               = 1'b0;
      res_push               = 1'b0;
      tmo_hit                = 1'b0;
      smp_ready              = 1'b0;
      cfg_busy               = 1'b0;
      fir_enable             = 1'b0;
      fir_configuration      = 1'b0;
      fir_config_data_enable = 1'b0;
      case (state)
         ST_IDLE: begin
            // run keeps smp_ready low while reset is asserted, even with fir_done high.
            smp_ready = run && fir_done && fifo_room && !cfg_pend && !cfg_start;
            if (cfg_start || cfg_pend) begin
               cfg_take  = 1'b1;
               state_nxt = ST_CFG_REQ;
            end else if (smp_valid && smp_ready) begin
               smp_xfer  = 1'b1;
               state_nxt = ST_LAUNCH;
            end
         end
         ST_CFG_REQ: begin
            cfg_busy          = 1'b1;
            fir_configuration = 1'b1;
            state_nxt         = ST_CFG_DATA;
         end
         ST_CFG_DATA: begin
            cfg_busy               = 1'b1;
            fir_config_data_enable = 1'b1;
            if (last_byte) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            fir_enable = 1'b1;
            state_nxt  = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (tmo_expired) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!fir_done) begin
               state_nxt = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            if (fir_done) begin
               res_push  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tmo_expired) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // fir_data_in is a register so it holds the last sample or config byte between transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         data_q   <= '0;
         byte_idx <= '0;
         cfg_pend <= 1'b0;
         tmo_cnt  <= '0;
         tmo_q    <= 1'b0;
      end else begin
         run <= 1'b1;
         if (smp_xfer) begin
            data_q <= smp_data;
         end else if (state == ST_CFG_REQ) begin
            data_q   <= DW'(tap_code);
            byte_idx <= '0;
         end else if ((state == ST_CFG_DATA) && !last_byte) begin
            data_q   <= coef[byte_idx[3:0]];
            byte_idx <= byte_idx + 5'd1;
         end

         if (cfg_take) begin
            cfg_pend <= 1'b0;
         end else if (cfg_start && in_flight) begin
            cfg_pend <= 1'b1;
         end

         if (state == ST_LAUNCH) begin
            tmo_cnt <= '0;
         end else if ((state == ST_WAIT_LO) || (state == ST_WAIT_HI)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         if (cfg_take) begin
            tmo_q <= 1'b0;
         end else if (tmo_hit) begin
            tmo_q <= 1'b1;
         end
      end
   end

   // Shadow writes are locked out during replay so the FIR sees one consistent coefficient set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_code <= '0;
         for (int i = 0; i < MAX_TAPS; i++) begin
            coef[i] <= '0;
         end
      end else if (cfg_wr && !cfg_busy) begin
         if (cfg_addr == ADDR_TAPS) begin
            tap_code <= cfg_wdata[3:0];
         end else if (cfg_addr <= ADDR_H_LAST) begin
            coef[4'(cfg_addr - ADDR_H_FIRST)] <= cfg_wdata;
         end
      end
   end

   assign push_word = {fir_overflow_flag, fir_data_out};

   fir_res_fifo #(
      .DEPTH (RES_DEPTH),
      .W     ($bits(res_t))
   ) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (res_push),
      .push_data (push_word),
      .pop       (res_valid && res_ready),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_cnt)
   );

   assign res_valid   = !fifo_empty;
   assign res_data    = fifo_head.data;
   assign res_ovf     = fifo_head.ovf;
   assign fir_data_in = data_q;
   assign tmo_err     = tmo_q;

`ifdef FIR_DRV_OVF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_pos_cnt <= '0;
         ovf_neg_cnt <= '0;
      end else if (cfg_take) begin
         ovf_pos_cnt <= '0;
         ovf_neg_cnt <= '0;
      end else if (res_push) begin
         if ((fir_overflow_flag == OVF_POS) && (ovf_pos_cnt != 16'hFFFF)) begin
            ovf_pos_cnt <= ovf_pos_cnt + 16'd1;
         end
         if ((fir_overflow_flag == OVF_NEG) && (ovf_neg_cnt != 16'hFFFF)) begin
            ovf_neg_cnt <= ovf_neg_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a behavioural FIR that drops fir_done for four cycles per launch.
`timescale 1ns/1ps
module tb_fir_stream_driver;
   import fir_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_wr;
   logic [4:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       cfg_start;
   logic       cfg_busy;
   logic       smp_valid;
   logic       smp_ready;
   logic [7:0] smp_data;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [1:0] res_ovf;
   logic       tmo_err;
   logic [7:0] fir_data_in;
   logic       fir_enable;
   logic       fir_configuration;
   logic       fir_config_data_enable;
   logic [7:0] fir_data_out;
   logic [1:0] fir_overflow_flag;
   logic       fir_done;
`ifdef FIR_DRV_OVF_CNT_EN
   logic [15:0] ovf_pos_cnt;
   logic [15:0] ovf_neg_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int launches = 0;
   int overlap  = 0;
   logic       fir_hang = 1'b0;
   logic [1:0] model_lat;
   logic [7:0] model_cap;
   logic [7:0] exp_bytes [5];

   always #5 clk = ~clk;

   fir_stream_driver #(.RES_DEPTH(4), .TMO_CYC(64)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .cfg_wr                 (cfg_wr),
      .cfg_addr               (cfg_addr),
      .cfg_wdata              (cfg_wdata),
      .cfg_start              (cfg_start),
      .cfg_busy               (cfg_busy),
      .smp_valid              (smp_valid),
      .smp_ready              (smp_ready),
      .smp_data               (smp_data),
      .res_valid              (res_valid),
      .res_ready              (res_ready),
      .res_data               (res_data),
      .res_ovf                (res_ovf),
      .tmo_err                (tmo_err),
      .fir_data_in            (fir_data_in),
      .fir_enable             (fir_enable),
      .fir_configuration      (fir_configuration),
      .fir_config_data_enable (fir_config_data_enable),
      .fir_data_out           (fir_data_out),
      .fir_overflow_flag      (fir_overflow_flag),
      .fir_done               (fir_done)
`ifdef FIR_DRV_OVF_CNT_EN
      ,
      .ovf_pos_cnt            (ovf_pos_cnt),
      .ovf_neg_cnt            (ovf_neg_cnt)
`endif
   );

   // FIR model: pass-through data, saturation flag for the two extreme codes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fir_done          <= 1'b1;
         model_lat         <= '0;
         model_cap         <= '0;
         fir_data_out      <= '0;
         fir_overflow_flag <= '0;
      end else if (fir_enable) begin
         fir_done  <= 1'b0;
         model_lat <= 2'd3;
         model_cap <= fir_data_in;
      end else if (model_lat != 0) begin
         model_lat <= model_lat - 2'd1;
      end else if (!fir_done && !fir_hang) begin
         fir_done          <= 1'b1;
         fir_data_out      <= model_cap;
         fir_overflow_flag <= (model_cap == 8'h7F) ? 2'b01 : (model_cap == 8'h80) ? 2'b10 : 2'b00;
      end
   end

   always @(posedge clk) begin
      if (rst_n && fir_enable) launches++;
      if (fir_enable && (fir_configuration || fir_config_data_enable)) overlap++;
   end

   task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
      cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic send_sample(input logic [7:0] d);
      int t;
      t = 0;
      smp_valid = 1'b1; smp_data = d;
      #1;
      while (smp_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t >= 100) begin
         n_fail++;
         $display("FAIL send_%h: smp_ready=%b after %0d cycles, required 1", d, smp_ready, t);
      end
      @(negedge clk);
      smp_valid = 1'b0;
   endtask

   task automatic pop_check(input logic [7:0] d, input logic [1:0] o);
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== d || res_ovf !== o) begin
         n_fail++;
         $display("FAIL pop_%h: valid=%b data=%h ovf=%b, required valid=1 data=%h ovf=%b",
                  d, res_valid, res_data, res_ovf, d, o);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic check_replay(input int nb);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      n_cmp++;
      if (fir_configuration !== 1'b1 || cfg_busy !== 1'b1 || smp_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_req: cfgreq=%b busy=%b smp_ready=%b, required 1 1 0",
                  fir_configuration, cfg_busy, smp_ready);
      end
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         n_cmp++;
         if (fir_config_data_enable !== 1'b1 || fir_configuration !== 1'b0 || fir_data_in !== exp_bytes[i]) begin
            n_fail++;
            $display("FAIL cfg_byte%0d: en=%b req=%b data=%h, required en=1 req=0 data=%h",
                     i, fir_config_data_enable, fir_configuration, fir_data_in, exp_bytes[i]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (fir_config_data_enable !== 1'b0 || cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_end: en=%b busy=%b, required 0 0", fir_config_data_enable, cfg_busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (cfg_busy !== 0 || smp_ready !== 0 || res_valid !== 0 || tmo_err !== 0 ||
          fir_enable !== 0 || fir_configuration !== 0 || fir_config_data_enable !== 0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy=%b srdy=%b rvld=%b tmo=%b en=%b req=%b cde=%b, required all 0",
                  cfg_busy, smp_ready, res_valid, tmo_err, fir_enable, fir_configuration, fir_config_data_enable);
      end
      n_cmp++;
      if (fir_data_in !== 8'h00 || res_data !== 8'h00 || res_ovf !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_data: din=%h rdata=%h rovf=%b, required 00 00 00", fir_data_in, res_data, res_ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (smp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: smp_ready=%b, required 1", smp_ready);
      end
   endtask

   task automatic test_config;
      cfg_write(5'd0, 8'h03);
      cfg_write(5'd1, 8'h40);
      cfg_write(5'd2, 8'h20);
      cfg_write(5'd3, 8'h10);
      cfg_write(5'd4, 8'h08);
      cfg_write(5'd17, 8'h99);
      exp_bytes[0] = 8'h03; exp_bytes[1] = 8'h40; exp_bytes[2] = 8'h20;
      exp_bytes[3] = 8'h10; exp_bytes[4] = 8'h08;
      check_replay(5);
   endtask

   task automatic test_stream;
      int la;
      la = launches;
      res_ready = 1'b0;
      send_sample(8'h7F);
      send_sample(8'h00);
      send_sample(8'h80);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (launches - la !== 3) begin
         n_fail++;
         $display("FAIL stream_launches: %0d, required 3", launches - la);
      end
      pop_check(8'h7F, 2'b01);
      pop_check(8'h00, 2'b00);
      pop_check(8'h80, 2'b10);
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_drained: res_valid=%b, required 0", res_valid);
      end
`ifdef FIR_DRV_OVF_CNT_EN
      n_cmp++;
      if (ovf_pos_cnt !== 16'd1 || ovf_neg_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL ovf_cnt: pos=%0d neg=%0d, required 1 1", ovf_pos_cnt, ovf_neg_cnt);
      end
`endif
   endtask

   task automatic test_backpressure;
      int la;
      la = launches;
      for (int i = 1; i <= 4; i++) send_sample(8'(i));
      repeat (10) @(negedge clk);
      n_cmp++;
      if (smp_ready !== 1'b0 || launches - la !== 4 || res_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full: srdy=%b launches=%0d rvld=%b, required 0 4 1",
                  smp_ready, launches - la, res_valid);
      end
      smp_valid = 1'b1; smp_data = 8'h05;
      repeat (6) @(negedge clk);
      n_cmp++;
      if (launches - la !== 4) begin
         n_fail++;
         $display("FAIL bp_blocked: launches=%0d, required 4", launches - la);
      end
      pop_check(8'h01, 2'b00);
      send_sample(8'h05);
      repeat (10) @(negedge clk);
      pop_check(8'h02, 2'b00);
      send_sample(8'h06);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (smp_ready !== 1'b0 || launches - la !== 6) begin
         n_fail++;
         $display("FAIL bp_refull: srdy=%b launches=%0d, required 0 6", smp_ready, launches - la);
      end
      pop_check(8'h03, 2'b00);
      pop_check(8'h04, 2'b00);
      pop_check(8'h05, 2'b00);
      pop_check(8'h06, 2'b00);
      n_cmp++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drained: res_valid=%b, required 0", res_valid);
      end
   endtask

   task automatic test_timeout;
      fir_hang = 1'b1;
      send_sample(8'h11);
      repeat (40) @(negedge clk);
      n_cmp++;
      if (tmo_err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_early: tmo_err=%b, required 0", tmo_err);
      end
      repeat (30) @(negedge clk);
      n_cmp++;
      if (tmo_err !== 1'b1 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_set: tmo_err=%b rvld=%b, required 1 0", tmo_err, res_valid);
      end
      fir_hang = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (smp_ready !== 1'b1 || res_valid !== 1'b0 || tmo_err !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_idle: srdy=%b rvld=%b tmo=%b, required 1 0 1", smp_ready, res_valid, tmo_err);
      end
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      n_cmp++;
      if (tmo_err !== 1'b0 || fir_configuration !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_clear: tmo_err=%b req=%b, required 0 1", tmo_err, fir_configuration);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_cfg_pending;
      int t;
      send_sample(8'h22);
      repeat (2) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      n_cmp++;
      if (cfg_busy !== 1'b0 || fir_configuration !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_hold: busy=%b req=%b, required 0 0", cfg_busy, fir_configuration);
      end
      t = 0;
      while (fir_configuration !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t >= 20 || res_valid !== 1'b1 || res_data !== 8'h22) begin
         n_fail++;
         $display("FAIL pend_start: waited=%0d rvld=%b rdata=%h, required <20 1 22", t, res_valid, res_data);
      end
      cfg_write(5'd1, 8'h77);
      repeat (8) @(negedge clk);
      pop_check(8'h22, 2'b00);
      check_replay(5);
   endtask

   task automatic test_reset_mid_cfg;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (fir_config_data_enable !== 0 || fir_configuration !== 0 || cfg_busy !== 0 ||
          fir_data_in !== 8'h00 || smp_ready !== 0 || res_valid !== 0) begin
         n_fail++;
         $display("FAIL async_rst: cde=%b req=%b busy=%b din=%h srdy=%b rvld=%b, required all 0",
                  fir_config_data_enable, fir_configuration, cfg_busy, fir_data_in, smp_ready, res_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_busy: cfg_busy=%b, required 0", cfg_busy);
      end
      exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h00;
      check_replay(2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_start = 1'b0;
      smp_valid = 1'b0; smp_data = '0; res_ready = 1'b0;
      @(negedge clk);
      test_reset;
      test_config;
      test_stream;
      test_backpressure;
      test_timeout;
      test_cfg_pending;
      test_reset_mid_cfg;
      n_cmp++;
      if (overlap !== 0) begin
         n_fail++;
         $display("FAIL strobe_overlap: %0d cycles, required 0", overlap);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
